// File: rtl/debounce_sync.sv
// debounce_sync: N-stage synchronizer + counter debounce filter with registered rise/fall pulses.
// Latency: din change sampled at edge 1 reaches dout at edge SYNC_STAGES+STABLE_CYCLES.
// Backpressure: none (level-in/level-out); DEBOUNCE_TOGGLE_EN adds a push-on/push-off `toggle` output.
module debounce_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
`ifdef DEBOUNCE_TOGGLE_EN
  output logic busy,
  output logic toggle
`else
  output logic busy
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_n;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_n;
  logic                   dout_n;
  logic                   rise_n;
  logic                   fall_n;
  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_q;
  logic                   mismatch;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], din};
    end
  end

  assign sync_q   = sync_ff[SYNC_STAGES-1];
  assign mismatch = sync_q ^ dout;

  // A flip loads the synchronized level and fires exactly one of rise/fall.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dout_n  = dout;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    case (state)
      IDLE: begin
        if (!mismatch) begin
          cnt_n = '0;
        end else if (STABLE_CYCLES == 1) begin
          dout_n  = sync_q;
          rise_n  = sync_q;
          fall_n  = ~sync_q;
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n   = CNT_W'(1);
          state_n = COUNT;
        end
      end
      COUNT: begin
        if (!mismatch) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else if (cnt == CNT_LAST) begin
          dout_n  = sync_q;
          rise_n  = sync_q;
          fall_n  = ~sync_q;
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      dout  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dout  <= dout_n;
      rise  <= rise_n;
      fall  <= fall_n;
      busy  <= (state_n == COUNT);
    end
  end

`ifdef DEBOUNCE_TOGGLE_EN
  // Toggles on the edge after the rise pulse, so it trails dout by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      toggle <= 1'b0;
    end else begin
      toggle <= toggle ^ rise;
    end
  end
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: directed vector table, bounded latency check, randomized run against a run-length model.
module tb_debounce_sync;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic dout, rise, fall, busy;
`ifdef DEBOUNCE_TOGGLE_EN
  logic toggle;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  debounce_sync #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .din (din),
    .dout(dout),
    .rise(rise),
    .fall(fall),
`ifdef DEBOUNCE_TOGGLE_EN
    .busy(busy),
    .toggle(toggle)
`else
    .busy(busy)
`endif
  );

  // Reference: din delayed SYNC edges, dout flips after STABLE consecutive mismatching samples.
  bit mq[$];
  bit m_dout, m_rise, m_fall, m_busy, m_tog;
  int m_run;

  function automatic void model_step(input bit r, input bit d);
    bit s;
    if (r) begin
      mq.delete();
      for (int i = 0; i < SYNC; i++) mq.push_back(1'b0);
      m_run = 0; m_dout = 0; m_rise = 0; m_fall = 0; m_busy = 0; m_tog = 0;
    end else begin
      m_tog = m_tog ^ m_rise;
      s = mq.pop_front();
      mq.push_back(d);
      m_rise = 0;
      m_fall = 0;
      if (s != m_dout) begin
        m_run++;
        if (m_run == STABLE) begin
          m_dout = s;
          m_rise = s;
          m_fall = !s;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
      m_busy = (m_run > 0);
    end
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick(input bit r, input bit d);
    rst = r;
    din = d;
    @(posedge clk);
    #1;
    cyc++;
    model_step(r, d);
  endtask

  typedef struct packed {
    bit rst; bit din; bit dout; bit rise; bit fall; bit busy;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input int n, input bit r, input bit d, input bit [3:0] exp);
    for (int i = 0; i < n; i++) tbl.push_back({r, d, exp[3], exp[2], exp[1], exp[0]});
  endfunction

  initial begin
    int cur, left, lat;
    bit r;
    for (int i = 0; i < SYNC; i++) mq.push_back(1'b0);

    // exp nibble = {dout, rise, fall, busy}
    add(2, 1, 1, 4'b0000);                       // reset with din high
    add(2, 0, 1, 4'b0000); add(3, 0, 1, 4'b0001); // rising edge held
    add(1, 0, 1, 4'b1100); add(2, 0, 1, 4'b1000);
    add(2, 0, 0, 4'b1000); add(3, 0, 0, 4'b1001); // falling edge held
    add(1, 0, 0, 4'b0010); add(2, 0, 0, 4'b0000);
    add(2, 0, 1, 4'b0000); add(1, 0, 1, 4'b0001); // 3-cycle glitch rejected
    add(2, 0, 0, 4'b0001); add(3, 0, 0, 4'b0000);
    add(2, 0, 1, 4'b0000); add(2, 0, 1, 4'b0001); // 4-cycle pulse accepted
    add(1, 0, 0, 4'b0001); add(1, 0, 0, 4'b1100);
    add(3, 0, 0, 4'b1001); add(1, 0, 0, 4'b0010); add(1, 0, 0, 4'b0000);
    add(2, 0, 1, 4'b0000); add(1, 0, 1, 4'b0001); // reset mid-count restarts latency
    add(1, 1, 1, 4'b0000);
    add(2, 0, 1, 4'b0000); add(3, 0, 1, 4'b0001);
    add(1, 0, 1, 4'b1100); add(1, 0, 1, 4'b1000);

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].rst, tbl[i].din);
      chk("tbl_dout", {7'd0, dout}, {7'd0, tbl[i].dout});
      chk("tbl_rise", {7'd0, rise}, {7'd0, tbl[i].rise});
      chk("tbl_fall", {7'd0, fall}, {7'd0, tbl[i].fall});
      chk("tbl_busy", {7'd0, busy}, {7'd0, tbl[i].busy});
      if (tbl[i].rst) chk("cnt_rst", 8'(dut.cnt), 8'd0);
    end

    // Bounded wait for rise after a clean 0->1 step.
    tick(1, 0);
    for (int i = 0; i < 4; i++) tick(0, 0);
    lat = 0;
    while (lat < 20) begin
      tick(0, 1);
      lat++;
      if (rise === 1'b1) break;
    end
    chk("rise_latency", 8'(lat), 8'(SYNC + STABLE));

`ifdef DEBOUNCE_TOGGLE_EN
    tick(1, 0);
    chk("tog_rst", {7'd0, toggle}, 8'd0);
    for (int p = 0; p < 2; p++) begin
      for (int i = 1; i <= 10; i++) begin
        tick(0, 1);
        if (i == SYNC + STABLE) chk("tog_at_rise", {7'd0, toggle}, {7'd0, p[0]});
        if (i == SYNC + STABLE + 1) chk("tog_after_rise", {7'd0, toggle}, {7'd0, ~p[0]});
      end
      for (int i = 0; i < 10; i++) tick(0, 0);
    end
    chk("tog_final", {7'd0, toggle}, 8'd0);
`endif

    // Randomized run lengths with sparse resets.
    cur  = 0;
    left = 0;
    for (int n = 0; n < 1500; n++) begin
      if (left == 0) begin
        cur  = 1 - cur;
        left = $urandom_range(1, 9);
      end
      left--;
      r = ($urandom_range(0, 99) == 0);
      tick(r, cur[0]);
      chk("rnd_dout", {7'd0, dout}, {7'd0, m_dout});
      chk("rnd_rise", {7'd0, rise}, {7'd0, m_rise});
      chk("rnd_fall", {7'd0, fall}, {7'd0, m_fall});
      chk("rnd_busy", {7'd0, busy}, {7'd0, m_busy});
      chk("rnd_cnt", 8'(dut.cnt), 8'(m_run));
`ifdef DEBOUNCE_TOGGLE_EN
      chk("rnd_tog", {7'd0, toggle}, {7'd0, m_tog});
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
